// File: rtl/program_counter_unit_if.sv
// Bundle between the FRANK6000 program counter, its sequencer-side driver and the instruction stack.
// slave = the program counter unit; master = whatever drives requests and supplies stack data.
interface program_counter_unit_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  i_en;
  logic                  i_halt;
  logic                  i_jmp;
  logic                  i_brn;
  logic                  i_cond;
  logic                  i_call;
  logic                  i_rtrn;
  logic [DATA_WIDTH-1:0] i_target;
  logic [DATA_WIDTH-1:0] i_stack;
  logic [DATA_WIDTH-1:0] o_PC;
  logic                  o_call;
  logic                  o_rtrn;
  logic                  o_busy;
  logic                  o_halted;
  logic                  o_ovf;
  logic                  o_unf;

  modport slave (
    input  i_en,
    input  i_halt,
    input  i_jmp,
    input  i_brn,
    input  i_cond,
    input  i_call,
    input  i_rtrn,
    input  i_target,
    input  i_stack,
    output o_PC,
    output o_call,
    output o_rtrn,
    output o_busy,
    output o_halted,
    output o_ovf,
    output o_unf
  );

  modport master (
    output i_en,
    output i_halt,
    output i_jmp,
    output i_brn,
    output i_cond,
    output i_call,
    output i_rtrn,
    output i_target,
    output i_stack,
    input  o_PC,
    input  o_call,
    input  o_rtrn,
    input  o_busy,
    input  o_halted,
    input  o_ovf,
    input  o_unf
  );

endinterface

// File: rtl/program_counter_unit.sv
// FRANK6000 program counter: next-PC selection, stack push/pop strobes, depth tracking
// and sticky overflow/underflow flags. Returns insert one bubble while stack data arrives.
module program_counter_unit #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic                   i_clk,
  input logic                   i_rst,
  program_counter_unit_if.slave bus
);

  localparam int unsigned          DEPTH_W   = ADDR_WIDTH + 1;
  localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(1 << ADDR_WIDTH);
  localparam logic [DEPTH_W-1:0]   DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DATA_WIDTH-1:0] PC_ONE   = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  call_c;
  logic                  rtrn_c;
  logic [DATA_WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + PC_ONE;

  // State register; reset also abandons any return in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state / next-PC selection, priority halt > rtrn > call > jmp > brn > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    call_c  = 1'b0;
    rtrn_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.i_en) begin
          if (bus.i_halt) begin
            state_d = ST_HALT;
          end else if (bus.i_rtrn) begin
            if (depth_q != '0) begin
              rtrn_c  = 1'b1;
              depth_d = depth_q - DEPTH_ONE;
              state_d = ST_RET_WAIT;
            end else begin
              unf_d = 1'b1;
              pc_d  = pc_inc;
            end
          end else if (bus.i_call) begin
            // The stack captures o_PC+1 on the same edge that loads the target.
            if (depth_q != DEPTH_MAX) begin
              call_c  = 1'b1;
              depth_d = depth_q + DEPTH_ONE;
              pc_d    = bus.i_target;
            end else begin
              ovf_d = 1'b1;
              pc_d  = pc_inc;
            end
          end else if (bus.i_jmp) begin
            pc_d = bus.i_target;
          end else if (bus.i_brn) begin
            pc_d = bus.i_cond ? bus.i_target : pc_inc;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      ST_RET_WAIT: begin
        // Stack read port is registered, so the popped address is valid now.
        pc_d    = bus.i_stack;
        state_d = ST_RUN;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.o_PC     = pc_q;
  assign bus.o_call   = call_c;
  assign bus.o_rtrn   = rtrn_c;
  assign bus.o_busy   = (state_q == ST_RET_WAIT);
  assign bus.o_halted = (state_q == ST_HALT);
  assign bus.o_ovf    = ovf_q;
  assign bus.o_unf    = unf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit with a small behavioural instruction stack
// (registered read port) attached to the push/pop strobes.
module tb_program_counter_unit;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  program_counter_unit_if #(.DATA_WIDTH(8)) bus ();

  program_counter_unit #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .RESET_VECTOR(8'h00)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction stack model: push o_PC+1 on o_call, registered read on o_rtrn.
  logic [7:0] stk_mem [16];
  logic [4:0] sp;
  logic [7:0] stk_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= 5'd0;
      stk_q <= 8'h00;
    end else if (bus.o_call && sp < 5'd16) begin
      stk_mem[sp[3:0]] <= bus.o_PC + 8'd1;
      sp               <= sp + 5'd1;
    end else if (bus.o_rtrn && sp > 5'd0) begin
      stk_q <= stk_mem[4'(sp - 5'd1)];
      sp    <= sp - 5'd1;
    end
  end

  assign bus.i_stack = stk_q;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic halt, input logic jmp, input logic brn,
                       input logic cond, input logic call, input logic rtrn, input logic [7:0] tgt);
    bus.i_en     = en;
    bus.i_halt   = halt;
    bus.i_jmp    = jmp;
    bus.i_brn    = brn;
    bus.i_cond   = cond;
    bus.i_call   = call;
    bus.i_rtrn   = rtrn;
    bus.i_target = tgt;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic jump_to(input logic [7:0] tgt);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tgt);
    tick();
  endtask

  logic [7:0] exp_ret;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();

    chk("rst_pc", bus.o_PC, 8'h00);
    chk("rst_busy", bus.o_busy, 8'd0);
    chk("rst_halted", bus.o_halted, 8'd0);
    chk("rst_ovf", bus.o_ovf, 8'd0);
    chk("rst_unf", bus.o_unf, 8'd0);
    chk("rst_call", bus.o_call, 8'd0);
    chk("rst_rtrn", bus.o_rtrn, 8'd0);
    rst = 1'b0;

    // Plain increment
    idle();
    chk("inc_pc0", bus.o_PC, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("inc_pc", bus.o_PC, 8'(i));
      chk("inc_call", bus.o_call, 8'd0);
      chk("inc_rtrn", bus.o_rtrn, 8'd0);
    end

    // Stall holds PC
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
    tick();
    chk("stall_pc", bus.o_PC, 8'h04);

    // Call then return
    jump_to(8'h05);
    chk("jmp_pc", bus.o_PC, 8'h05);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
    chk("call_strobe", bus.o_call, 8'd1);
    tick();
    chk("call_pc", bus.o_PC, 8'h40);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("ret_strobe", bus.o_rtrn, 8'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
    tick();
    chk("ret_busy", bus.o_busy, 8'd1);
    chk("ret_hold_pc", bus.o_PC, 8'h40);
    chk("ret_wait_call", bus.o_call, 8'd0);
    chk("ret_wait_rtrn", bus.o_rtrn, 8'd0);
    tick();
    chk("ret_pc", bus.o_PC, 8'h06);
    chk("ret_busy_clr", bus.o_busy, 8'd0);

    // Underflow
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_strobe", bus.o_rtrn, 8'd0);
    tick();
    chk("unf_pc", bus.o_PC, 8'h07);
    chk("unf_flag", bus.o_unf, 8'd1);
    chk("unf_busy", bus.o_busy, 8'd0);

    // 16 nested calls fill the stack; first pushes 0x08
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
      chk("nest_call", bus.o_call, 8'd1);
      tick();
      chk("nest_pc", bus.o_PC, 8'(8'h20 + i));
    end
    chk("nest_ovf_clr", bus.o_ovf, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
    chk("ovf_strobe", bus.o_call, 8'd0);
    tick();
    chk("ovf_pc", bus.o_PC, 8'h30);
    chk("ovf_flag", bus.o_ovf, 8'd1);

    // Unwind: LIFO order of pushed return addresses
    for (int j = 0; j < 16; j++) begin
      exp_ret = (j == 15) ? 8'h08 : 8'(8'h20 + 15 - j);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("unwind_strobe", bus.o_rtrn, 8'd1);
      tick();
      chk("unwind_busy", bus.o_busy, 8'd1);
      tick();
      chk("unwind_pc", bus.o_PC, exp_ret);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("empty_strobe", bus.o_rtrn, 8'd0);
    tick();
    chk("empty_pc", bus.o_PC, 8'h09);
    chk("ovf_sticky", bus.o_ovf, 8'd1);
    chk("unf_sticky", bus.o_unf, 8'd1);

    // Branches
    jump_to(8'h10);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    tick();
    chk("brn_nt_pc", bus.o_PC, 8'h11);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
    tick();
    chk("brn_t_pc", bus.o_PC, 8'h80);

    // Wrap at max address
    jump_to(8'hFF);
    chk("wrap_pre", bus.o_PC, 8'hFF);
    idle();
    tick();
    chk("wrap_pc", bus.o_PC, 8'h00);

    // Call beats jump; return lands on 0x01
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50);
    chk("cj_strobe", bus.o_call, 8'd1);
    tick();
    chk("cj_pc", bus.o_PC, 8'h50);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    tick();
    chk("cj_ret_pc", bus.o_PC, 8'h01);

    // Reset while waiting for return data
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    chk("rw_busy", bus.o_busy, 8'd1);
    rst = 1'b1;
    #1;
    chk("rw_rst_pc", bus.o_PC, 8'h00);
    chk("rw_rst_busy", bus.o_busy, 8'd0);
    chk("rw_rst_ovf", bus.o_ovf, 8'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk("rw_resume_pc", bus.o_PC, 8'h01);

    // Halt outranks return and freezes everything
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("halt_rtrn", bus.o_rtrn, 8'd0);
    tick();
    chk("halt_flag", bus.o_halted, 8'd1);
    chk("halt_pc", bus.o_PC, 8'h01);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    chk("halt_call", bus.o_call, 8'd0);
    tick();
    tick();
    chk("halt_frozen", bus.o_PC, 8'h01);
    chk("halt_stays", bus.o_halted, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
